// File: rtl/heater_supervisor.sv
// heater_supervisor: staggered ramp, per-channel clear-and-retry,
// and latched fault reporting for Nchan heater channels.
module heater_supervisor #(
   parameter int Nchan      = 16,
   parameter int STAGGER    = 1024,
   parameter int CLR_CYCLES = 4,
   parameter int HOLDOFF    = 16,
   parameter int Nretry     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_req,
   input  logic [Nchan-1:0] chan_mask,
   input  logic             fault_clear,
   input  logic [Nchan-1:0] heater_error,
   output logic [Nchan-1:0] heater_enable,
   output logic [Nchan-1:0] heater_err_clear,
   output logic [Nchan-1:0] fault,
   output logic             busy,
   output logic             all_on
);

   localparam int IW   = $clog2(Nchan + 1);
   localparam int SW   = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int TMAX = (CLR_CYCLES > HOLDOFF) ? CLR_CYCLES : HOLDOFF;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, RAMP, RUN} top_t;
   typedef enum logic [2:0] {OFF, ON, CLEAR, HOLD, FAULT} ch_t;

   top_t             st, st_nx;
   logic [IW-1:0]    idx, idx_nx, pick;
   logic [SW-1:0]    cnt, cnt_nx;
   logic             found;
   logic [Nchan-1:0] err_q, start, fault_q, fault_nx;
   ch_t              ch_st [Nchan];
   ch_t              ch_nx [Nchan];
   logic [TW-1:0]    tmr [Nchan];
   logic [TW-1:0]    tmr_nx [Nchan];
   logic [3:0]       rc [Nchan];
   logic [3:0]       rc_nx [Nchan];

   // First permitted, non-faulted channel at or beyond the ramp index
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int j = 0; j < Nchan; j++) begin
         if (!found && IW'(j) >= idx && chan_mask[j] && !fault_q[j]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   always_comb begin
      st_nx  = st;
      idx_nx = idx;
      cnt_nx = cnt;
      unique case (st)
         IDLE: begin
            if (run_req) begin
               st_nx  = RAMP;
               idx_nx = '0;
               cnt_nx = '0;
            end
         end
         RAMP: begin
            if (!run_req) st_nx = IDLE;
            else if (cnt != '0) cnt_nx = cnt - SW'(1);
            else if (found) begin
               idx_nx = pick + IW'(1);
               cnt_nx = SW'(STAGGER - 1);
            end else st_nx = RUN;
         end
         RUN: if (!run_req) st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_comb begin
      for (int j = 0; j < Nchan; j++) begin
         start[j] = (st == RAMP) && run_req && (cnt == '0)
                    && found && (pick == IW'(j));
      end
   end

   always_comb begin
      logic [3:0] inc;
      logic       fset;
      inc  = '0;
      fset = 1'b0;
      for (int i = 0; i < Nchan; i++) begin
         ch_nx[i]    = ch_st[i];
         tmr_nx[i]   = tmr[i];
         rc_nx[i]    = rc[i];
         fault_nx[i] = fault_q[i];
         inc  = (rc[i] == 4'hf) ? rc[i] : rc[i] + 4'h1;
         fset = 1'b0;
         if (!run_req) begin
            ch_nx[i]  = OFF;
            tmr_nx[i] = '0;
            rc_nx[i]  = '0;
         end else begin
            unique case (ch_st[i])
               OFF: if (start[i]) ch_nx[i] = ON;
               ON: begin
                  if (!chan_mask[i]) ch_nx[i] = OFF;
                  else if (err_q[i]) begin
                     ch_nx[i]  = CLEAR;
                     tmr_nx[i] = TW'(CLR_CYCLES - 1);
                  end
               end
               CLEAR: begin
                  if (tmr[i] != '0) tmr_nx[i] = tmr[i] - TW'(1);
                  else begin
                     rc_nx[i] = inc;
                     if (int'(inc) > Nretry) begin
                        ch_nx[i] = FAULT;
                        fset     = 1'b1;
                     end else if (HOLDOFF == 0) ch_nx[i] = ON;
                     else begin
                        ch_nx[i]  = HOLD;
                        tmr_nx[i] = TW'(HOLDOFF - 1);
                     end
                  end
               end
               HOLD: begin
                  if (tmr[i] != '0) tmr_nx[i] = tmr[i] - TW'(1);
                  else ch_nx[i] = ON;
               end
               FAULT: ch_nx[i] = FAULT;
               default: ch_nx[i] = OFF;
            endcase
         end
         if (fset) fault_nx[i] = 1'b1;
         // A fault being set this cycle survives a coincident clear
         if (fault_clear) begin
            rc_nx[i] = '0;
            if (!fset) fault_nx[i] = 1'b0;
            if (ch_st[i] == FAULT) ch_nx[i] = OFF;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st      <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         err_q   <= '0;
         fault_q <= '0;
         for (int i = 0; i < Nchan; i++) begin
            ch_st[i] <= OFF;
            tmr[i]   <= '0;
            rc[i]    <= '0;
         end
      end else begin
         st      <= st_nx;
         idx     <= idx_nx;
         cnt     <= cnt_nx;
         err_q   <= heater_error;
         fault_q <= fault_nx;
         for (int i = 0; i < Nchan; i++) begin
            ch_st[i] <= ch_nx[i];
            tmr[i]   <= tmr_nx[i];
            rc[i]    <= rc_nx[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < Nchan; i++) begin
         heater_enable[i]    = (ch_st[i] == ON) || (ch_st[i] == HOLD);
         heater_err_clear[i] = (ch_st[i] == CLEAR);
      end
   end

   assign fault  = fault_q;
   assign busy   = (st == RAMP);
   assign all_on = (st == RUN);

endmodule

// File: tb/tb_heater_supervisor.sv
// tb_heater_supervisor: directed plan steps plus random traffic,
// checked against a cycle-level behavioural model of the supervisor.
module tb_heater_supervisor;

   localparam int N   = 4;
   localparam int STG = 8;
   localparam int CLR = 4;
   localparam int HO  = 5;
   localparam int NR  = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         run_req = 1'b0;
   logic         fault_clear = 1'b0;
   logic [N-1:0] chan_mask = '0;
   logic [N-1:0] heater_error = '0;
   logic [N-1:0] heater_enable, heater_err_clear, fault;
   logic         busy, all_on;

   int checks = 0;
   int errors = 0;

   heater_supervisor #(
      .Nchan(N), .STAGGER(STG), .CLR_CYCLES(CLR),
      .HOLDOFF(HO), .Nretry(NR)
   ) dut (
      .clk(clk), .reset(reset), .run_req(run_req),
      .chan_mask(chan_mask), .fault_clear(fault_clear),
      .heater_error(heater_error), .heater_enable(heater_enable),
      .heater_err_clear(heater_err_clear), .fault(fault),
      .busy(busy), .all_on(all_on)
   );

   always #5 clk = ~clk;

   // Behavioural model: remaining-cycle counters per channel
   bit m_ramping, m_running;
   int m_idx, m_wait;
   bit m_errq [N];
   bit m_active [N];
   int m_clr [N];
   int m_hold [N];
   bit m_dead [N];
   bit m_fault [N];
   int m_retries [N];

   function void model_reset();
      m_ramping = 0; m_running = 0; m_idx = 0; m_wait = 0;
      for (int i = 0; i < N; i++) begin
         m_errq[i] = 0; m_active[i] = 0; m_clr[i] = 0; m_hold[i] = 0;
         m_dead[i] = 0; m_fault[i] = 0; m_retries[i] = 0;
      end
   endfunction

   function void model_step();
      bit errq_old [N];
      int start;
      bit fset;
      errq_old = m_errq;
      for (int i = 0; i < N; i++) m_errq[i] = heater_error[i];
      if (!run_req) begin
         m_ramping = 0; m_running = 0;
         for (int i = 0; i < N; i++) begin
            m_active[i] = 0; m_clr[i] = 0; m_hold[i] = 0;
            m_dead[i] = 0; m_retries[i] = 0;
            if (fault_clear) m_fault[i] = 0;
         end
         return;
      end
      start = -1;
      if (!m_ramping && !m_running) begin
         m_ramping = 1; m_idx = 0; m_wait = 0;
      end else if (m_ramping) begin
         if (m_wait > 0) m_wait--;
         else begin
            for (int j = m_idx; j < N && start < 0; j++)
               if (chan_mask[j] && !m_fault[j]) start = j;
            if (start >= 0) begin
               m_idx = start + 1; m_wait = STG - 1;
            end else begin
               m_ramping = 0; m_running = 1;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         fset = 0;
         if (m_dead[i]) begin
         end else if (m_clr[i] > 0) begin
            if (m_clr[i] == 1) begin
               m_clr[i] = 0;
               if (m_retries[i] < 15) m_retries[i]++;
               if (m_retries[i] > NR) begin
                  m_dead[i] = 1; m_active[i] = 0; fset = 1;
               end else m_hold[i] = HO;
            end else m_clr[i]--;
         end else if (m_hold[i] > 0) m_hold[i]--;
         else if (m_active[i]) begin
            if (!chan_mask[i]) m_active[i] = 0;
            else if (errq_old[i]) m_clr[i] = CLR;
         end else if (i == start) m_active[i] = 1;
         if (fault_clear) begin
            m_retries[i] = 0;
            if (!fset) begin
               m_fault[i] = 0;
               if (m_dead[i]) begin m_dead[i] = 0; m_active[i] = 0; end
            end
         end
         if (fset) m_fault[i] = 1;
      end
   endfunction

   function logic [N-1:0] exp_en();
      for (int i = 0; i < N; i++)
         exp_en[i] = m_active[i] && m_clr[i] == 0 && !m_dead[i];
   endfunction

   function logic [N-1:0] exp_ec();
      for (int i = 0; i < N; i++) exp_ec[i] = (m_clr[i] > 0);
   endfunction

   function logic [N-1:0] exp_flt();
      for (int i = 0; i < N; i++) exp_flt[i] = m_fault[i];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic compare_all();
      chk("enable", heater_enable, exp_en());
      chk("err_clear", heater_err_clear, exp_ec());
      chk("fault", fault, exp_flt());
      chk("busy", busy, m_ramping);
      chk("all_on", all_on, m_running);
      chk("exclusive", heater_enable & heater_err_clear, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int  pulses;
      bit  prev;
      bit  hit;
      model_reset();
      repeat (2) tick();
      chk("reset_en", heater_enable, 0);
      chk("reset_flt", fault, 0);
      #2 reset = 1'b0;
      tick();

      chan_mask = 4'b1011;
      run_req   = 1'b1;
      for (int c = 0; c <= 26; c++) begin
         tick();
         if (c == 0)  chk("ramp_busy", busy, 1);
         if (c == 1)  chk("ramp_c1", heater_enable, 4'b0001);
         if (c == 8)  chk("ramp_c8", heater_enable, 4'b0001);
         if (c == 9)  chk("ramp_c9", heater_enable, 4'b0011);
         if (c == 16) chk("ramp_c16", heater_enable, 4'b0011);
         if (c == 17) chk("ramp_c17", heater_enable, 4'b1011);
         if (c == 24) chk("ramp_c24_on", all_on, 0);
         if (c == 25) chk("ramp_c25_on", all_on, 1);
      end

      heater_error = 4'b0010;
      for (int k = 1; k <= 8; k++) begin
         tick();
         heater_error = '0;
         if (k >= 2 && k <= 5) chk("retry_clr", heater_err_clear, 4'b0010);
         if (k == 2) chk("retry_en", heater_enable, 4'b1001);
         if (k == 6) chk("retry_back", heater_enable, 4'b1011);
      end
      repeat (10) tick();
      chk("retry_nofault", fault, 0);

      heater_error = 4'b0001;
      pulses = 0;
      prev   = 0;
      for (int k = 0; k < 200 && !m_fault[0]; k++) begin
         tick();
         if (heater_err_clear[0] && !prev) pulses++;
         prev = heater_err_clear[0];
      end
      chk("exhaust_pulses", pulses, 4);
      chk("exhaust_fault", fault, 4'b0001);
      repeat (20) tick();
      chk("exhaust_off", heater_enable[0], 0);
      heater_error = '0;
      tick();

      heater_error = 4'b1000;
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
         if (m_clr[3] == 1 && m_retries[3] == NR) begin
            fault_clear = 1'b1;
            hit = 1;
         end
         tick();
         fault_clear = 1'b0;
      end
      chk("simul_reached", hit, 1);
      chk("simul_fault", fault, 4'b1000);
      heater_error = '0;
      tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      chk("fclr_fault", fault, 0);
      chk("fclr_off", heater_enable & 4'b1001, 0);

      run_req = 1'b0;
      tick();
      chk("idle_en", heater_enable, 0);
      chan_mask = 4'b1111;
      run_req   = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         tick();
         if (c == 10) begin
            chk("abort_c10", heater_enable, 4'b0011);
            run_req = 1'b0;
         end
         if (c == 11) chk("abort_c11", heater_enable, 0);
      end
      run_req = 1'b1;
      tick();
      tick();
      chk("restart_c1", heater_enable, 4'b0001);

      heater_error = 4'b0001;
      tick();
      heater_error = '0;
      tick();
      chk("pre_rst_clr", heater_err_clear[0], 1);
      #2 reset = 1'b1;
      #1;
      chk("async_en", heater_enable, 0);
      chk("async_clr", heater_err_clear, 0);
      chk("async_busy", busy, 0);
      model_reset();
      tick();
      #2 reset = 1'b0;

      for (int k = 0; k < 4000; k++) begin
         run_req = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 49) == 0) chan_mask = N'($urandom);
         for (int i = 0; i < N; i++)
            heater_error[i] = ($urandom_range(0, 29) == 0);
         fault_clear = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
